atom_rom_loader: RTL and testbench
==================================

// Module: atom_rom_loader
// PURPOSE
//  Sits between hps_io's ioctl download port and the 192k system spram. Captures 16-bit ioctl words, splits each into two byte writes at BASE_ADDR+offset.
//  Owns the spram bus during a download and keeps AtomFpga_Core in reset until the image is resident.
//  Default target is utility ROM slot 7 (0x17000).
// PARAMETERS
//  DL_INDEX    8'd1       ioctl_index value this loader accepts; other indices are ignored.
//  BASE_ADDR   18'h17000  spram byte address of offset 0.
//  MAX_BYTES   4096       window size in bytes; bytes at offset >= MAX_BYTES are dropped.
//  HOLD_CYC    16         cycles core_hold stays high after ioctl_download falls.
// PORTS
//  clk_sys         in   1   system clock; also clocks hps_io and spram.
//  reset           in   1   synchronous, active-high.
//  ioctl_download  in   1   hps_io download active.
//  ioctl_index     in   8   download slot index.
//  ioctl_wr        in   1   one-cycle strobe, word valid.
//  ioctl_addr      in   25  byte address of the word's low byte; always even (WIDE=1).
//  ioctl_dout      in   16  [7:0] = byte at addr, [15:8] = byte at addr+1.
//  ioctl_wait      out  1   stall to hps_io while a word is being written.
//  core_addr       in   18  core ExternA.
//  core_din        in   8   core ExternDin.
//  core_we         in   1   core ExternWE.
//  mem_addr        out  18  to spram address.
//  mem_din         out  8   to spram data.
//  mem_we          out  1   to spram wren.
//  core_hold       out  1   ORed into core ext reset.
//  dl_done         out  1   one-cycle pulse when a matching download ends.
//  dl_overflow     out  1   sticky; a byte fell outside the window. Cleared at the start of the next matching download.
// BEHAVIOUR
//  - Reset: state IDLE. ioctl_wait=0, mem_we passes core_we, core_hold=0, dl_done=0, dl_overflow=0, hold counter=0.
//  - active = ioctl_download && ioctl_index==DL_INDEX. It is sampled when entering ARMED and stays latched until ioctl_download falls.
//  - FSM states: IDLE, ARMED, WR_LO, WR_HI, HOLD.
//    IDLE -> ARMED when active. On that edge, clear dl_overflow.
//    ARMED, ioctl_wr=1: latch addr/data, assert ioctl_wait, go to WR_LO.
//    WR_LO: mem_we=1, mem_addr=BASE_ADDR+off, mem_din=dout[7:0]. Go to WR_HI.
//    WR_HI: mem_we=1, addr+1, dout[15:8]. Go to ARMED and drop ioctl_wait.
//    ARMED, !ioctl_download: pulse dl_done, load the hold counter, go to HOLD.
//    HOLD: decrement the counter; at 0 go to IDLE.
//  - Write rule: 2 cycles per word, so ioctl_wait is high in WR_LO and WR_HI only. A strobe arriving while ioctl_wait=1 is a protocol violation and is ignored.
//  - Window check per byte: off = ioctl_addr (+1 for the hi byte), compared at 25-bit width.
//    If off >= MAX_BYTES, force mem_we=0 for that byte and set dl_overflow. The FSM still steps through WR_LO and WR_HI, so timing is identical.
//  - Bus mux: in IDLE, mem_* = core_*.
//    In any other state, mem_addr/din come from the loader, and mem_we is the loader's write enable (0 in ARMED/HOLD).
//    core_we is discarded outside IDLE.
//  - core_hold = (state != IDLE).
//  - A non-matching index never leaves IDLE; the core bus stays transparent and ioctl_wait stays 0.
//  - If ioctl_download falls during WR_LO/WR_HI, finish the word, then go ARMED -> HOLD on the next cycle.
//  - Reset mid-download: return to IDLE at once. Any partial word is lost. The HPS restarts the transfer.
//  - Address arithmetic: BASE_ADDR + off[17:0], truncated to 18 bits. Overflow cannot occur for the default values.
// STRUCTURE
//  - Single module, no sub-modules. Hold counter width = $clog2(HOLD_CYC+1).
//  - State enum and the spram slot base constants (ROM_SLOT7=18'h17000, BBC_BASE=18'h20000) go in the shared atom_mem_pkg.
// TESTING
//  1. idx=1, words {0x0000:0xBBAA}, {0x0002:0xDDCC} -> spram 0x17000..3 = AA BB CC DD; ioctl_wait high exactly 2 cycles per word.
//  2. idx=2 download of 8 bytes -> no mem_we from the loader, core_hold=0, core writes pass through unchanged.
//  3. idx=1 word at addr 0x0FFE then 0x1000 -> 0x17FFE/0x17FFF written, nothing written at 0x18000, dl_overflow=1.
//  4. End of download -> dl_done for 1 cycle, core_hold stays high for 16 more cycles, then core_we=1 at 0x00100 writes spram.
//  5. Core asserts core_we during ARMED -> spram unchanged at core_addr.
//  6. reset asserted in WR_LO -> next cycle IDLE, ioctl_wait=0, core_hold=0, mem_we follows core_we.

Source files
------------

// File: rtl/atom_mem_pkg.sv
// Shared Atom memory map constants and the ROM loader state type.
// Slot bases are spram byte addresses.
package atom_mem_pkg;

  localparam logic [17:0] ROM_SLOT7 = 18'h17000;
  localparam logic [17:0] BBC_BASE  = 18'h20000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WR_LO,
    S_WR_HI,
    S_HOLD
  } ld_state_e;

endpackage

// File: rtl/atom_rom_loader.sv
// ioctl word download into spram as byte pairs.
// Holds the core in reset until the image is resident.
module atom_rom_loader
  import atom_mem_pkg::*;
#(
  parameter logic [7:0]  DL_INDEX  = 8'd1,
  parameter logic [17:0] BASE_ADDR = ROM_SLOT7,
  parameter int          MAX_BYTES = 4096,
  parameter int          HOLD_CYC  = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic [17:0] core_addr,
  input  logic [7:0]  core_din,
  input  logic        core_we,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        core_hold,
  output logic        dl_done,
  output logic        dl_overflow
);

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
  localparam logic [24:0]   MAX_OFF = 25'(MAX_BYTES);

  ld_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [24:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        ovf_q, ovf_d;

  logic [24:0] off;
  logic        in_win;
  logic        ld_we;
  logic [17:0] ld_addr;
  logic [7:0]  ld_byte;
  logic        is_idle;

  assign off     = (state_q == S_WR_HI) ? addr_q + 25'd1 : addr_q;
  assign in_win  = off < MAX_OFF;
  assign ld_addr = BASE_ADDR + off[17:0];
  assign ld_byte = (state_q == S_WR_HI) ? data_q[15:8]
                                        : data_q[7:0];
  assign is_idle = (state_q == S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    ld_we   = 1'b0;
    dl_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ioctl_download && ioctl_index == DL_INDEX) begin
          state_d = S_ARMED;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (!ioctl_download) begin
          dl_done = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else if (ioctl_wr) begin
          addr_d  = ioctl_addr;
          data_d  = ioctl_dout;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO, S_WR_HI: begin
        // Out-of-window bytes still take their cycle.
        ld_we = in_win;
        if (!in_win) ovf_d = 1'b1;
        state_d = (state_q == S_WR_LO) ? S_WR_HI : S_ARMED;
      end
      S_HOLD: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr    = is_idle ? core_addr : ld_addr;
  assign mem_din     = is_idle ? core_din  : ld_byte;
  assign mem_we      = is_idle ? core_we   : ld_we;
  assign ioctl_wait  = (state_q == S_WR_LO) || (state_q == S_WR_HI);
  assign core_hold   = !is_idle;
  assign dl_overflow = ovf_q;

endmodule

// File: tb/tb_atom_rom_loader.sv
// Bench for atom_rom_loader: table vectors, corner sequences
// and randomized downloads against a byte-level memory model.
module tb_atom_rom_loader;

  localparam int BASE = 32'h17000;
  localparam int MAXB = 4096;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [17:0] core_addr;
  logic [7:0]  core_din;
  logic        core_we;
  logic [17:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        core_hold;
  logic        dl_done;
  logic        dl_overflow;

  atom_rom_loader dut (
    .clk_sys(clk), .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .core_addr(core_addr), .core_din(core_din),
    .core_we(core_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we),
    .core_hold(core_hold), .dl_done(dl_done),
    .dl_overflow(dl_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:262143] = '{default: 8'h00};
  logic [7:0] expm [0:262143] = '{default: 8'h00};

  always @(posedge clk)
    if (mem_we) ram[mem_addr] <= mem_din;

  int  total = 0;
  int  bad = 0;
  bit  ovf_m;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
    logic        ovf;
  } vec_t;
  vec_t tv [4];

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_cmp(string nm);
    int n = 0;
    int first = -1;
    for (int i = 0; i < 262144; i++)
      if (ram[i] !== expm[i]) begin
        n++;
        if (first < 0) first = i;
      end
    if (n != 0)
      $display("  first diff at %h: ram=%h model=%h",
               first, ram[first], expm[first]);
    chk(nm, n, 0);
  endtask

  task automatic model_byte(int off, logic [7:0] b);
    if (off < MAXB) expm[(BASE + off) % 262144] = b;
    else ovf_m = 1'b1;
  endtask

  task automatic core_write(logic [17:0] a, logic [7:0] d);
    core_we = 1'b1; core_addr = a; core_din = d;
    #1;
    chk("core_pass_we", mem_we, 1'b1);
    chk("core_pass_addr", mem_addr, a);
    expm[a] = d;
    tick();
    core_we = 1'b0;
  endtask

  task automatic start_dl(logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    if (idx == 8'd1) ovf_m = 1'b0;
    tick();
    chk("hold_on_start", core_hold, idx == 8'd1);
  endtask

  task automatic send_word(logic [24:0] a, logic [15:0] d,
                           bit match);
    int n = 0;
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    while (ioctl_wait && n < 10) begin
      n++;
      tick();
    end
    chk("wait_cycles", n, match ? 2 : 0);
    if (match) begin
      model_byte(int'(a), d[7:0]);
      model_byte(int'(a) + 1, d[15:8]);
    end
  endtask

  task automatic end_dl(bit match);
    int n = 0;
    ioctl_download = 1'b0;
    #1;
    chk("dl_done_pulse", dl_done, match);
    tick();
    chk("dl_done_gone", dl_done, 1'b0);
    while (core_hold && n < 40) begin
      n++;
      tick();
    end
    chk("hold_cycles", n, match ? HOLD : 0);
    chk("overflow_flag", dl_overflow, ovf_m);
  endtask

  initial begin
    tv[0] = '{25'h0000, 16'hBBAA, 1'b0};
    tv[1] = '{25'h0002, 16'hDDCC, 1'b0};
    tv[2] = '{25'h0FFE, 16'h2211, 1'b0};
    tv[3] = '{25'h1000, 16'h4433, 1'b1};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    core_addr = '0; core_din = '0; core_we = 1'b0;
    ovf_m = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_hold", core_hold, 1'b0);
    chk("rst_done", dl_done, 1'b0);
    chk("rst_ovf", dl_overflow, 1'b0);
    core_we = 1'b1;
    #1;
    chk("rst_we_pass", mem_we, 1'b1);
    core_we = 1'b0;
    #1;
    chk("rst_we_pass0", mem_we, 1'b0);

    // Table words: in-window pair, then window edge.
    start_dl(8'd1);
    for (int i = 0; i < 4; i++) begin
      send_word(tv[i].addr, tv[i].data, 1'b1);
      chk("tv_ovf", dl_overflow, tv[i].ovf);
    end
    chk("b17000", ram[18'h17000], 8'hAA);
    chk("b17001", ram[18'h17001], 8'hBB);
    chk("b17002", ram[18'h17002], 8'hCC);
    chk("b17003", ram[18'h17003], 8'hDD);
    chk("b17FFE", ram[18'h17FFE], 8'h11);
    chk("b17FFF", ram[18'h17FFF], 8'h22);
    chk("b18000", ram[18'h18000], 8'h00);
    chk("b18001", ram[18'h18001], 8'h00);

    // Core write while ARMED must not reach spram.
    core_we = 1'b1; core_addr = 18'h00100; core_din = 8'h77;
    #1;
    chk("armed_we_block", mem_we, 1'b0);
    tick();
    core_we = 1'b0;
    chk("armed_ram", ram[18'h00100], 8'h00);
    end_dl(1'b1);
    core_write(18'h00100, 8'h3C);
    chk("post_hold_ram", ram[18'h00100], 8'h3C);
    chk("ovf_kept", dl_overflow, 1'b1);

    // Foreign index: loader stays transparent.
    start_dl(8'd2);
    for (int i = 0; i < 4; i++) begin
      send_word(25'(2 * i), 16'hE0E0 + 16'(i), 1'b0);
      chk("idx2_hold", core_hold, 1'b0);
      core_write(18'h00200 + 18'(i), 8'h50 + 8'(i));
    end
    end_dl(1'b0);
    ram_cmp("ram_after_idx2");

    // Reset during WR_LO: low byte lands, high byte lost.
    start_dl(8'd1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 16'h9988;
    tick();
    ioctl_wr = 1'b0;
    chk("wrlo_wait", ioctl_wait, 1'b1);
    reset = 1'b1;
    tick();
    model_byte(16, 8'h88);
    chk("mid_rst_wait", ioctl_wait, 1'b0);
    chk("mid_rst_hold", core_hold, 1'b0);
    chk("mid_rst_ovf", dl_overflow, 1'b0);
    core_we = 1'b1; core_addr = 18'h00300; core_din = 8'h11;
    #1;
    chk("mid_rst_we", mem_we, 1'b1);
    chk("mid_rst_addr", mem_addr, 18'h00300);
    expm[18'h00300] = 8'h11;
    tick();
    core_we = 1'b0; reset = 1'b0; ioctl_download = 1'b0;
    tick();
    ram_cmp("ram_after_reset");

    // Randomized downloads mixed with idle core traffic.
    for (int d = 0; d < 4; d++) begin
      logic [7:0] idx;
      bit m;
      idx = ($urandom_range(0, 3) == 0) ? 8'd3 : 8'd1;
      m = (idx == 8'd1);
      core_write(18'($urandom_range(0, 18'h3FFFF)),
                 8'($urandom));
      start_dl(idx);
      for (int w = 0; w < 20; w++) begin
        if (m && $urandom_range(0, 4) == 0) begin
          core_we = 1'b1;
          core_addr = 18'($urandom_range(0, 18'h3FFFF));
          core_din = 8'($urandom);
          tick();
          core_we = 1'b0;
        end
        send_word(25'($urandom_range(0, 2100) * 2),
                  16'($urandom), m);
      end
      end_dl(m);
      ram_cmp("ram_random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
